memory_flash_arbiter: RTL and testbench

Shares the single read port of the embedded flash memory block between two requesters: port A (CPU) and port B (N64 PI). Each request is won by round-robin arbitration. The arbiter issues one read at a time downstream and routes the returned data to the owner. A watchdog completes a read with all-ones data if the memory never acknowledges, so neither requester can hang.

---
 rtl/memory_flash_arbiter.sv | 160 ++++++++++++++++
 tb/tb_memory_flash_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_flash_arbiter.sv
// Round-robin arbiter sharing the flash read port between port A (CPU) and port B (N64 PI).
// One read is in flight at a time; a watchdog completes a read with all-ones data if no ack arrives.
module memory_flash_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_a_request,
  output logic        o_a_busy,
  output logic        o_a_ack,
  input  logic [18:0] i_a_address,
  output logic [31:0] o_a_data,

  input  logic        i_b_request,
  output logic        o_b_busy,
  output logic        o_b_ack,
  input  logic [18:0] i_b_address,
  output logic [31:0] o_b_data,

  output logic        o_mem_request,
  input  logic        i_mem_busy,
  input  logic        i_mem_ack,
  output logic [18:0] o_mem_address,
  input  logic [31:0] i_mem_data,

  output logic        o_timeout
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        prio_b_q, prio_b_d;    // port that wins a tie: 0 = A, 1 = B
  logic        owner_b_q, owner_b_d;
  logic [18:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        a_ack_q, a_ack_d;
  logic        b_ack_q, b_ack_d;
  logic        timeout_q, timeout_d;
  logic [31:0] a_data_q, a_data_d;
  logic [31:0] b_data_q, b_data_d;

  logic        sel_b;
  logic        complete;
  logic [31:0] done_data;

  // Port that would be granted in IDLE this cycle.
  always_comb begin
    if (i_a_request && i_b_request) begin
      sel_b = prio_b_q;
    end else if (i_b_request) begin
      sel_b = 1'b1;
    end else if (i_a_request) begin
      sel_b = 1'b0;
    end else begin
      sel_b = prio_b_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_b_d  = prio_b_q;
    owner_b_d = owner_b_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    timeout_d = 1'b0;
    a_data_d  = a_data_q;
    b_data_d  = b_data_q;
    complete  = 1'b0;
    done_data = '0;

    unique case (state_q)
      StIdle: begin
        if (i_a_request || i_b_request) begin
          owner_b_d = sel_b;
          prio_b_d  = ~sel_b;
          addr_d    = sel_b ? i_b_address : i_a_address;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (!i_mem_busy) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        // A real ack beats the watchdog when both land in the same cycle.
        if (i_mem_ack) begin
          complete  = 1'b1;
          done_data = i_mem_data;
        end else if (cnt_q == TimeoutLast) begin
          complete  = 1'b1;
          done_data = 32'hFFFF_FFFF;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      state_d = StIdle;
      if (owner_b_q) begin
        b_ack_d  = 1'b1;
        b_data_d = done_data;
      end else begin
        a_ack_d  = 1'b1;
        a_data_d = done_data;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= StIdle;
      prio_b_q  <= 1'b0;
      owner_b_q <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      timeout_q <= 1'b0;
      a_data_q  <= '0;
      b_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      prio_b_q  <= prio_b_d;
      owner_b_q <= owner_b_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      timeout_q <= timeout_d;
      a_data_q  <= a_data_d;
      b_data_q  <= b_data_d;
    end
  end

  always_comb begin
    o_a_busy      = (state_q != StIdle) | sel_b;
    o_b_busy      = (state_q != StIdle) | ~sel_b;
    o_mem_request = (state_q == StIssue);
    o_mem_address = addr_q;
    o_a_ack       = a_ack_q;
    o_b_ack       = b_ack_q;
    o_a_data      = a_data_q;
    o_b_data      = b_data_q;
    o_timeout     = timeout_q;
  end

endmodule

// File: tb/tb_memory_flash_arbiter.sv
// Self-checking bench for memory_flash_arbiter: transaction-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_memory_flash_arbiter;

  localparam int TO = 8;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_a_request = 1'b0;
  logic [18:0] i_a_address = '0;
  logic        i_b_request = 1'b0;
  logic [18:0] i_b_address = '0;
  logic        i_mem_busy;
  logic        i_mem_ack;
  logic [31:0] i_mem_data;
  logic        o_a_busy, o_a_ack, o_b_busy, o_b_ack, o_mem_request, o_timeout;
  logic [31:0] o_a_data, o_b_data;
  logic [18:0] o_mem_address;

  memory_flash_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_a_request  (i_a_request),
    .o_a_busy     (o_a_busy),
    .o_a_ack      (o_a_ack),
    .i_a_address  (i_a_address),
    .o_a_data     (o_a_data),
    .i_b_request  (i_b_request),
    .o_b_busy     (o_b_busy),
    .o_b_ack      (o_b_ack),
    .i_b_address  (i_b_address),
    .o_b_data     (o_b_data),
    .o_mem_request(o_mem_request),
    .i_mem_busy   (i_mem_busy),
    .i_mem_ack    (i_mem_ack),
    .o_mem_address(o_mem_address),
    .i_mem_data   (i_mem_data),
    .o_timeout    (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          cyc = 0;
  bit          m_txn = 0, m_issued = 0, m_owner_b = 0, m_prio_b = 0;
  logic [18:0] m_addr = '0;
  int          m_acc_cyc = 0;
  bit          m_a_ack = 0, m_b_ack = 0, m_timeout = 0;
  logic [31:0] m_a_data = '0, m_b_data = '0;

  function automatic bit pick_b();
    if (i_a_request && i_b_request) return m_prio_b;
    return i_b_request;
  endfunction

  initial begin
    forever begin
      bit          pb;
      logic [31:0] d;
      @(posedge i_clk or posedge i_reset);
      if (i_reset) begin
        m_txn = 0; m_issued = 0; m_owner_b = 0; m_prio_b = 0; m_addr = '0;
        m_a_ack = 0; m_b_ack = 0; m_timeout = 0; m_a_data = '0; m_b_data = '0;
      end else begin
        m_a_ack = 0; m_b_ack = 0; m_timeout = 0;
        if (!m_txn) begin
          if (i_a_request || i_b_request) begin
            pb = pick_b();
            m_txn = 1; m_issued = 0; m_owner_b = pb; m_prio_b = !pb;
            m_addr = pb ? i_b_address : i_a_address;
          end
        end else if (!m_issued) begin
          if (!i_mem_busy) begin
            m_issued = 1;
            m_acc_cyc = cyc;
          end
        end else if (i_mem_ack || cyc == m_acc_cyc + TO) begin
          d = i_mem_ack ? i_mem_data : 32'hFFFF_FFFF;
          if (m_owner_b) begin m_b_ack = 1; m_b_data = d; end
          else begin m_a_ack = 1; m_a_data = d; end
          m_timeout = !i_mem_ack;
          m_txn = 0;
        end
        cyc++;
      end
    end
  end

  // ---------------- compare process and event log ----------------
  bit          grants[$];
  int          n_a_ack = 0, n_b_ack = 0, n_to = 0;
  int          a_ack_cyc = 0, b_ack_cyc = 0, to_cyc = 0, ds_cyc = 0;
  logic [31:0] a_last = '0, b_last = '0;
  logic [18:0] ds_addr = '0, run_addr = '0;
  int          run = 0, last_run = 0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        chk("a_ack", o_a_ack, m_a_ack);
        chk("b_ack", o_b_ack, m_b_ack);
        chk("a_data", o_a_data, m_a_data);
        chk("b_data", o_b_data, m_b_data);
        chk("timeout", o_timeout, m_timeout);
        chk("mem_request", o_mem_request, m_txn && !m_issued);
        chk("mem_address", o_mem_address, m_addr);
        if (m_txn) begin
          chk("a_busy_inflight", o_a_busy, 1);
          chk("b_busy_inflight", o_b_busy, 1);
        end else begin
          if (i_a_request) chk("a_busy_idle", o_a_busy, pick_b());
          if (i_b_request) chk("b_busy_idle", o_b_busy, !pick_b());
        end
        if (i_a_request && !o_a_busy) grants.push_back(1'b0);
        if (i_b_request && !o_b_busy) grants.push_back(1'b1);
        if (o_a_ack) begin n_a_ack++; a_ack_cyc = cyc; a_last = o_a_data; end
        if (o_b_ack) begin n_b_ack++; b_ack_cyc = cyc; b_last = o_b_data; end
        if (o_timeout) begin n_to++; to_cyc = cyc; end
        if (o_mem_request && !i_mem_busy) begin ds_cyc = cyc; ds_addr = o_mem_address; end
        if (o_mem_request) begin
          if (run > 0 && o_mem_address == run_addr) run++;
          else begin run = 1; run_addr = o_mem_address; end
        end else if (run > 0) begin
          last_run = run;
          run = 0;
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  int          r_busy = 0, r_delay = 2, r_cnt = 0;
  bit          r_noack = 0, r_ovr = 0, r_pend = 0, r_poke = 0;
  logic [31:0] r_data = '0;
  logic [18:0] r_addr = '0;

  initial begin
    i_mem_busy = 1'b0;
    i_mem_ack  = 1'b0;
    i_mem_data = '0;
    forever begin
      @(posedge i_clk);
      #1;
      i_mem_ack = 1'b0;
      if (i_reset) begin
        r_pend = 0;
        i_mem_busy = 1'b0;
      end else begin
        if (r_poke) begin
          i_mem_ack = 1'b1;
          i_mem_data = 32'hDEAD_BEEF;
          r_poke = 0;
        end
        if (r_pend) begin
          r_cnt--;
          if (r_cnt == 0) begin
            r_pend = 0;
            if (!r_noack) begin
              i_mem_ack = 1'b1;
              i_mem_data = r_ovr ? r_data : {13'd0, r_addr};
            end
          end
        end else if (o_mem_request) begin
          if (r_busy > 0) begin
            i_mem_busy = 1'b1;
            r_busy--;
          end else begin
            i_mem_busy = 1'b0;
            r_pend = 1;
            r_cnt = r_delay;
            r_addr = o_mem_address;
          end
        end else begin
          i_mem_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cfg(input int busy, input int delay, input bit noack, input bit ovr,
                     input logic [31:0] data);
    r_busy = busy; r_delay = delay; r_noack = noack; r_ovr = ovr; r_data = data;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic req(input bit pb, input logic [18:0] addr);
    bit ok;
    ok = 0;
    if (pb) begin i_b_request = 1'b1; i_b_address = addr; end
    else begin i_a_request = 1'b1; i_a_address = addr; end
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge i_clk);
      ok = pb ? !o_b_busy : !o_a_busy;
      next_cycle();
    end
    i_a_request = 1'b0;
    i_b_request = 1'b0;
    chk("req_accepted_in_bound", ok, 1);
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (m_txn && i < 200) begin
      next_cycle();
      i++;
    end
    chk("idle_in_bound", i < 200, 1);
    next_cycle();
  endtask

  task automatic both_req(input int n, input logic [18:0] a0, input logic [18:0] b0);
    int ng;
    bit acc_a, acc_b;
    ng = 0;
    i_a_address = a0; i_b_address = b0;
    i_a_request = 1'b1; i_b_request = 1'b1;
    for (int i = 0; i < 300 && ng < n; i++) begin
      @(negedge i_clk);
      acc_a = !o_a_busy;
      acc_b = !o_b_busy;
      next_cycle();
      if (acc_a) begin ng++; i_a_address = i_a_address + 19'd1; end
      if (acc_b) begin ng++; i_b_address = i_b_address + 19'd1; end
    end
    i_a_request = 1'b0;
    i_b_request = 1'b0;
    chk("grants_in_bound", ng, n);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    next_cycle();
    next_cycle();
    i_reset = 1'b0;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int a0, b0, t0;
    logic [3:0] pat;

    next_cycle();
    next_cycle();
    chk("rst_mem_request", o_mem_request, 0);
    chk("rst_mem_address", o_mem_address, 0);
    chk("rst_a_data", o_a_data, 0);
    chk("rst_b_data", o_b_data, 0);
    chk("rst_timeout", o_timeout, 0);
    i_reset = 1'b0;
    next_cycle();

    // Single A read
    cfg(0, 2, 0, 1, 32'h1234_5678);
    a0 = n_a_ack; b0 = n_b_ack;
    req(1'b0, 19'h00010);
    wait_idle();
    chk("t1_mem_address", ds_addr, 19'h00010);
    chk("t1_a_ack_count", n_a_ack - a0, 1);
    chk("t1_b_ack_count", n_b_ack - b0, 0);
    chk("t1_a_data", a_last, 32'h1234_5678);
    chk("t1_latency", a_ack_cyc - ds_cyc, 3);

    // Simultaneous requests after reset alternate A,B,A,B
    do_reset();
    cfg(0, 3, 0, 0, 0);
    grants.delete();
    a0 = n_a_ack; b0 = n_b_ack;
    both_req(4, 19'h00100, 19'h00200);
    wait_idle();
    pat = 4'b1010;
    chk("t2_grant_count", grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grants.size()) chk("t2_grant_order", grants[i], pat[i]);
    end
    chk("t2_a_acks", n_a_ack - a0, 2);
    chk("t2_b_acks", n_b_ack - b0, 2);

    // Downstream backpressure for 5 cycles
    cfg(5, 2, 0, 0, 0);
    a0 = n_a_ack;
    req(1'b0, 19'h00055);
    wait_idle();
    chk("t3_request_run", last_run, 6);
    chk("t3_a_acks", n_a_ack - a0, 1);
    chk("t3_a_data", a_last, 32'h0000_0055);

    // Timeout, then a late ack that must be discarded
    cfg(0, 2, 1, 0, 0);
    b0 = n_b_ack; t0 = n_to;
    req(1'b1, 19'h00077);
    wait_idle();
    chk("t4_timeout_latency", to_cyc - ds_cyc, 9);
    chk("t4_b_acks", n_b_ack - b0, 1);
    chk("t4_timeouts", n_to - t0, 1);
    chk("t4_b_data", b_last, 32'hFFFF_FFFF);
    chk("t4_ack_with_timeout", b_ack_cyc, to_cyc);
    #1;
    r_poke = 1;
    repeat (5) next_cycle();
    chk("t4_late_ack_ignored", n_b_ack - b0, 1);
    chk("t4_no_extra_timeout", n_to - t0, 1);

    // Ack lands on the last counted cycle
    cfg(0, TO, 0, 1, 32'hCAFE_0001);
    a0 = n_a_ack; t0 = n_to;
    req(1'b0, 19'h00099);
    wait_idle();
    chk("t5_a_data", a_last, 32'hCAFE_0001);
    chk("t5_no_timeout", n_to - t0, 0);
    chk("t5_a_acks", n_a_ack - a0, 1);
    chk("t5_latency", a_ack_cyc - ds_cyc, 9);

    // Reset while B's read is in WAIT
    cfg(0, 6, 0, 0, 0);
    b0 = n_b_ack;
    req(1'b1, 19'h00123);
    next_cycle();
    next_cycle();
    #3;
    i_reset = 1'b1;
    #1;
    chk("t6_rst_mem_request", o_mem_request, 0);
    chk("t6_rst_mem_address", o_mem_address, 0);
    chk("t6_rst_a_ack", o_a_ack, 0);
    chk("t6_rst_b_ack", o_b_ack, 0);
    chk("t6_rst_a_data", o_a_data, 0);
    chk("t6_rst_b_data", o_b_data, 0);
    chk("t6_rst_timeout", o_timeout, 0);
    next_cycle();
    next_cycle();
    i_reset = 1'b0;
    repeat (10) next_cycle();
    chk("t6_no_b_ack", n_b_ack - b0, 0);
    grants.delete();
    both_req(2, 19'h00300, 19'h00400);
    wait_idle();
    chk("t6_grant_count", grants.size(), 2);
    if (grants.size() >= 2) begin
      chk("t6_first_grant_a", grants[0], 0);
      chk("t6_second_grant_b", grants[1], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
